pkt_loader: RTL and testbench
=============================

Name: pkt_loader

Overview:
- Ingress stage directly upstream of the per-packet processing block.
- Accepts a byte stream with valid/ready/last, captures the first HDR_MAX_LEN bytes into a zero-padded header buffer, and counts the full packet length.
- Launches processing with a level start / level ready handshake and holds the header stable until processing completes, then reports completion.

Parameters:
- HDR_MAX_LEN, 64: header buffer depth in bytes; must match the processing block's header array size.
- LEN_W, 16: packet length counter width.
- TIMEOUT_CYCLES, 1024: maximum cycles to wait for proc_ready_i after the guard period.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input byte valid.
- in_data_i  in  8  input byte.
- in_last_i  in  1  marks the final byte of a packet; qualified by in_valid_i.
- in_ready_o  out  1  loader accepts a byte this cycle.
- pkt_hdr_o  out  8 x HDR_MAX_LEN  header buffer; index 0 holds the first byte.
- proc_start_o  out  1  level start to the processing block.
- proc_ready_i  in  1  level ready from the processing block.
- pkt_len_o  out  LEN_W  byte count of the last packet; saturates at all-ones.
- trunc_o  out  1  last packet was longer than HDR_MAX_LEN; valid with done_o.
- done_o  out  1  one-cycle pulse: packet finished.
- timeout_o  out  1  one-cycle pulse coincident with done_o when processing timed out.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - All pkt_hdr_o bytes = 0; pkt_len_o = 0.
  - proc_start_o, done_o, timeout_o, trunc_o, busy_o = 0.
  - in_ready_o = 1 once reset is released.
  - Reset mid-packet abandons the packet; no done_o is produced for it.
- A byte is accepted when in_valid_i and in_ready_o are both high.
- in_ready_o = 1 in IDLE, LOAD and DRAIN; 0 in START and RELEASE.
- States:
  - IDLE: on an accepted byte:
    - pkt_hdr[0] = byte; all other pkt_hdr bytes cleared to 0 in the same cycle.
    - Byte count = 1; trunc cleared.
    - Next state: START if in_last_i, else LOAD.
  - LOAD: each accepted byte is written to pkt_hdr[count] and count increments.
    - in_last_i → START.
    - Byte written at index HDR_MAX_LEN-1 without last → DRAIN.
  - DRAIN: accepted bytes are discarded; count still increments; trunc set on the first discarded byte.
    - in_last_i → START.
  - START: proc_start_o = 1.
    - Guard counter runs for 2 cycles; proc_ready_i is ignored during the guard because a stale ready from the previous packet may still be high.
    - After the guard, proc_ready_i = 1 → RELEASE.
    - After the guard, the wait counter reaching TIMEOUT_CYCLES without ready → RELEASE with the timeout flag set.
  - RELEASE: proc_start_o = 0; done_o pulses for this single cycle; timeout_o pulses if flagged.
    - pkt_len_o and trunc_o are updated in the same cycle as done_o.
    - Next state: IDLE.
- Latencies:
  - proc_start_o rises the cycle after the last byte is accepted.
  - done_o rises 1 cycle after proc_ready_i is sampled high post-guard.
  - Minimum gap from the falling edge of proc_start_o to the next possible rise is 2 cycles: RELEASE→IDLE, then at least one byte of loading. This lets the processing block return to free.
- pkt_hdr_o is stable from the START-entry cycle through RELEASE.
- The count saturates at 2^LEN_W-1 with no wrap; DRAIN continues until last.
- in_valid_i is ignored when in_ready_o = 0; there is no buffering and the upstream must hold the byte.
- proc_ready_i high outside START is ignored.

Test Plan:
- 14-byte packet 0x01..0x0E, last on byte 14 → pkt_hdr[0..13] = 01..0E, [14..63] = 0; start rises the cycle after the last byte; ready returned 5 cycles later → done_o 1 cycle after ready; pkt_len_o = 14, trunc_o = 0.
- 100-byte packet → pkt_hdr holds the first 64 bytes; bytes 65..100 are discarded; pkt_len_o = 100, trunc_o = 1.
- Single byte 0xAA with last → pkt_hdr[0] = AA, rest 0; pkt_len_o = 1; a prior packet's nonzero bytes are fully cleared.
- proc_ready_i held high from the previous packet when start rises → not accepted during the 2 guard cycles; if ready then drops and returns 3 cycles later, completion follows that return.
- proc_ready_i never asserted, TIMEOUT_CYCLES = 16 → start high for 2 + 16 cycles, then done_o and timeout_o pulse together; next packet accepted normally.
- rst low mid-LOAD at byte 7 → start, done and busy are 0 immediately and pkt_hdr is cleared; a following 4-byte packet completes with pkt_len_o = 4.

Source files
------------

// File: rtl/pkt_loader.sv
// Ingress loader: captures the packet header into a zero-padded buffer, counts the length,
// then holds the header while the processing block runs under a level start/ready handshake.
module pkt_loader #(
  parameter int unsigned HDR_MAX_LEN    = 64,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_i,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_last_i,
  output logic                         in_ready_o,
  output logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_o,
  output logic                         proc_start_o,
  input  logic                         proc_ready_i,
  output logic [LEN_W-1:0]             pkt_len_o,
  output logic                         trunc_o,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic                         busy_o
);

  localparam int unsigned IdxW = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
  localparam int unsigned CycW = $clog2(TIMEOUT_CYCLES + 3);

  localparam logic [CycW-1:0]  GuardLast = CycW'(1);
  localparam logic [CycW-1:0]  WaitLast  = CycW'(TIMEOUT_CYCLES + 1);
  localparam logic [LEN_W-1:0] HdrLast   = LEN_W'(HDR_MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LenOne    = LEN_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StStart,
    StRelease
  } state_e;

  state_e state_q, state_d;

  logic [HDR_MAX_LEN-1:0][7:0] hdr_q, hdr_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [LEN_W-1:0]            cnt_inc;
  logic [CycW-1:0]             cyc_q, cyc_d;
  logic                        trunc_q, trunc_d;
  logic                        trunc_out_q, trunc_out_d;
  logic                        to_q, to_d;

  logic accept;
  logic guard_done;
  logic ready_ok;
  logic wait_expired;

  assign accept       = in_valid_i & in_ready_o;
  // A ready left high by the previous packet must not complete this one.
  assign guard_done   = (cyc_q > GuardLast);
  assign ready_ok     = guard_done & proc_ready_i;
  assign wait_expired = guard_done & (cyc_q == WaitLast);
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + LenOne;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_last_i) begin
            state_d = StStart;
          end else if (HDR_MAX_LEN == 1) begin
            state_d = StDrain;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (accept) begin
          if (in_last_i) begin
            state_d = StStart;
          end else if (cnt_q == HdrLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept && in_last_i) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (ready_ok || wait_expired) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    hdr_d       = hdr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    cyc_d       = cyc_q;
    trunc_d     = trunc_q;
    trunc_out_d = trunc_out_q;
    to_d        = to_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hdr_d    = '0;
          hdr_d[0] = in_data_i;
          cnt_d    = LenOne;
          trunc_d  = 1'b0;
          to_d     = 1'b0;
          cyc_d    = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          hdr_d[cnt_q[IdxW-1:0]] = in_data_i;
          cnt_d                  = cnt_inc;
        end
      end
      StDrain: begin
        if (accept) begin
          cnt_d   = cnt_inc;
          trunc_d = 1'b1;
        end
      end
      StStart: begin
        cyc_d = cyc_q + CycW'(1);
        if (ready_ok || wait_expired) begin
          len_d       = cnt_q;
          trunc_out_d = trunc_q;
          to_d        = ~ready_ok;
        end
      end
      StRelease: begin
        cyc_d = '0;
      end
      default: begin
        cyc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      cyc_q       <= '0;
      trunc_q     <= 1'b0;
      trunc_out_q <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      hdr_q       <= hdr_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      cyc_q       <= cyc_d;
      trunc_q     <= trunc_d;
      trunc_out_q <= trunc_out_d;
      to_q        <= to_d;
    end
  end

  // Outputs
  always_comb begin
    in_ready_o   = 1'b0;
    proc_start_o = 1'b0;
    done_o       = 1'b0;
    timeout_o    = 1'b0;
    busy_o       = (state_q != StIdle);
    unique case (state_q)
      StIdle, StLoad, StDrain: in_ready_o = 1'b1;
      StStart:                 proc_start_o = 1'b1;
      StRelease: begin
        done_o    = 1'b1;
        timeout_o = to_q;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase
  end

  assign pkt_hdr_o = hdr_q;
  assign pkt_len_o = len_q;
  assign trunc_o   = trunc_out_q;

endmodule

// File: tb/tb_pkt_loader.sv
// Scoreboard bench for pkt_loader: expected header/length/flags are queued when a packet is
// driven and compared when done_o pulses; handshake timing is checked inline.
module tb_pkt_loader;

  localparam int HDR = 64;
  localparam int LW  = 16;
  localparam int TO  = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  in_valid = 1'b0;
  logic [7:0]            in_data = '0;
  logic                  in_last = 1'b0;
  logic                  in_ready;
  logic [HDR-1:0][7:0]   pkt_hdr;
  logic                  proc_start;
  logic                  proc_ready = 1'b0;
  logic [LW-1:0]         pkt_len;
  logic                  trunc;
  logic                  done;
  logic                  timeout;
  logic                  busy;

  typedef struct {
    logic [LW-1:0]      len;
    logic               trunc;
    logic               to;
    logic [HDR*8-1:0]   hdr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  pkt_loader #(
    .HDR_MAX_LEN   (HDR),
    .LEN_W         (LW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .pkt_hdr_o   (pkt_hdr),
    .proc_start_o(proc_start),
    .proc_ready_i(proc_ready),
    .pkt_len_o   (pkt_len),
    .trunc_o     (trunc),
    .done_o      (done),
    .timeout_o   (timeout),
    .busy_o      (busy)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return (seed == 0) ? 8'(i + 1) : 8'(seed + i * 13);
  endfunction

  // Scoreboard: compare against the oldest expected packet whenever done pulses.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 512'(1), 512'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_len", 512'(pkt_len), 512'(e.len));
        check("sb_trunc", 512'(trunc), 512'(e.trunc));
        check("sb_timeout", 512'(timeout), 512'(e.to));
        check("sb_hdr", 512'(pkt_hdr), 512'(e.hdr));
      end
    end
  end

  task automatic send_pkt(input int n, input int seed, input bit exp_to, input bit with_last);
    exp_t e;
    int   w;
    e.hdr = '0;
    for (int i = 0; i < n && i < HDR; i++) e.hdr[i*8 +: 8] = pat(seed, i);
    e.len   = LW'(n);
    e.trunc = (n > HDR);
    e.to    = exp_to;
    if (with_last) sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pat(seed, i);
      in_last  = with_last && (i == n - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 50) check("in_ready_wait", 512'(0), 512'(1));
      if (i == n - 1) check("start_before_last", 512'(proc_start), 512'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (with_last) check("start_rise", 512'(proc_start), 512'(1));
  endtask

  // Return ready d cycles after the start rise, then expect done on the following cycle.
  task automatic respond(input int d, input bit keep);
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      check("start_held", 512'(proc_start), 512'(1));
      check("no_early_done", 512'(done), 512'(0));
    end
    proc_ready = 1'b1;
    @(posedge clk); #1;
    check("done_latency", 512'(done), 512'(1));
    check("start_fall", 512'(proc_start), 512'(0));
    check("no_timeout", 512'(timeout), 512'(0));
    if (!keep) proc_ready = 1'b0;
    @(posedge clk); #1;
    check("done_one_cycle", 512'(done), 512'(0));
    check("busy_idle", 512'(busy), 512'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 512'(proc_start), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_hdr", 512'(pkt_hdr), 512'(0));
    check("rst_len", 512'(pkt_len), 512'(0));
    check("rst_trunc", 512'(trunc), 512'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 512'(in_ready), 512'(1));

    // 14-byte packet, ready returned 5 cycles after start
    send_pkt(14, 0, 1'b0, 1'b1);
    respond(5, 1'b0);

    // 100-byte packet: truncated header, full length
    send_pkt(100, 3, 1'b0, 1'b1);
    respond(2, 1'b0);

    // Single byte clears the previous header; leave ready high afterwards
    send_pkt(1, 8'hAA, 1'b0, 1'b1);
    respond(3, 1'b1);

    // Stale ready: high through both guard cycles, then drops and returns 3 cycles later
    send_pkt(3, 8'h41, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("guard_no_done", 512'(done), 512'(0));
      check("guard_start", 512'(proc_start), 512'(1));
    end
    proc_ready = 1'b0;
    respond(3, 1'b0);

    // Timeout: start held for guard plus TO cycles
    send_pkt(5, 8'h30, 1'b1, 1'b1);
    cnt = 0;
    while (proc_start && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("timeout_start_cycles", 512'(cnt), 512'(2 + TO));
    check("timeout_done", 512'(done), 512'(1));
    check("timeout_pulse", 512'(timeout), 512'(1));
    @(posedge clk); #1;
    check("timeout_one_cycle", 512'(timeout), 512'(0));

    // Reset mid-load at byte 7
    send_pkt(7, 8'h60, 1'b0, 1'b0);
    check("midload_busy", 512'(busy), 512'(1));
    rst = 1'b0;
    #1;
    check("midrst_start", 512'(proc_start), 512'(0));
    check("midrst_done", 512'(done), 512'(0));
    check("midrst_busy", 512'(busy), 512'(0));
    check("midrst_hdr", 512'(pkt_hdr), 512'(0));
    check("midrst_len", 512'(pkt_len), 512'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", 512'(in_ready), 512'(1));

    // Clean 4-byte packet after reset
    send_pkt(4, 8'h55, 1'b0, 1'b1);
    respond(2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 512'(sb_q.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
